// File: rtl/pkt_demux_pkg.sv
// Shared types and constants for the message-aware 1-to-2 demux.
package pkt_demux_pkg;

    // Message framing state: at a boundary, or inside a multi-flit message.
    typedef enum logic {
        DEMUX_IDLE = 1'b0,
        DEMUX_BUSY = 1'b1
    } demux_state_e;

    localparam logic DEMUX_DST0 = 1'b0;
    localparam logic DEMUX_DST1 = 1'b1;

endpackage

// File: rtl/demux_skid_buf.sv
// Two-entry registered FIFO with val/rdy on both sides.
// The head entry drives the outputs directly from a register, and the input
// ready is derived only from the fill level, so there is no combinational path
// from the downstream ready back to the upstream ready.
module demux_skid_buf #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_val,
    input  logic [W-1:0] i_data,
    output logic         o_rdy,
    output logic         o_val,
    output logic [W-1:0] o_data,
    input  logic         i_rdy
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_rdy  = (r_cnt != 2'd2);
    assign o_val  = (r_cnt != 2'd0);
    assign o_data = r_head;
    assign w_push = i_val & o_rdy;
    assign w_pop  = o_val & i_rdy;

    // Fill-level driven head/tail update; a push into a one-entry buffer that
    // is popped in the same cycle lands straight in the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head <= i_data;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail <= i_data;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pkt_demux2.sv
// Message-aware 1-to-2 flit splitter. Each whole message is steered to dst0
// or dst1 according to src_sel on its first flit; each output is buffered
// two deep so a stalled destination only blocks the source while selected.
// Optional per-destination delivered-message counters: PKT_DEMUX_CNT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// DEMUX_IDLE | at a message boundary; route follows src_sel
// DEMUX_BUSY | inside a multi-flit message; route locked to r_route
module pkt_demux2
    import pkt_demux_pkg::*;
#(
    parameter int DATA_W = -1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_val,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_last,
    input  logic              src_sel,
    output logic              src_rdy,
    output logic              dst0_val,
    output logic [DATA_W-1:0] dst0_data,
    output logic              dst0_last,
    input  logic              dst0_rdy,
    output logic              dst1_val,
    output logic [DATA_W-1:0] dst1_data,
    output logic              dst1_last,
    input  logic              dst1_rdy
`ifdef PKT_DEMUX_CNT_EN
   ,output logic [CNT_W-1:0]  dst0_msg_cnt,
    output logic [CNT_W-1:0]  dst1_msg_cnt
`endif
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("pkt_demux2: DATA_W must be overridden with a value >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pkt_demux2: CNT_W must be >= 1");
    end

    demux_state_e      r_state;
    demux_state_e      w_state_nxt;
    logic              r_route;
    logic              w_route_nxt;
    logic              w_route;
    logic              w_accept;
    logic [1:0]        w_buf_rdy;
    logic              w_push0;
    logic              w_push1;
    logic [DATA_W:0]   w_src_flit;
    logic [DATA_W:0]   w_dst0_flit;
    logic [DATA_W:0]   w_dst1_flit;

    assign w_route    = (r_state == DEMUX_IDLE) ? src_sel : r_route;
    assign src_rdy    = w_buf_rdy[w_route];
    assign w_accept   = src_val & src_rdy;
    assign w_push0    = w_accept & (w_route == DEMUX_DST0);
    assign w_push1    = w_accept & (w_route == DEMUX_DST1);
    assign w_src_flit = {src_last, src_data};

    // Framing state and locked destination register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEMUX_IDLE;
            r_route <= DEMUX_DST0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
        end
    end

    // Next state: a multi-flit message locks its first-flit destination until
    // its last flit; single-flit messages leave the lock register alone.
    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        case (r_state)
            DEMUX_IDLE: begin
                if (w_accept && !src_last) begin
                    w_state_nxt = DEMUX_BUSY;
                    w_route_nxt = src_sel;
                end
            end
            DEMUX_BUSY: begin
                if (w_accept && src_last) begin
                    w_state_nxt = DEMUX_IDLE;
                end
            end
            default: begin
                w_state_nxt = DEMUX_IDLE;
            end
        endcase
    end

    demux_skid_buf #(.W(DATA_W + 1)) u_buf0 (
        .clk    (clk),
        .rst    (rst),
        .i_val  (w_push0),
        .i_data (w_src_flit),
        .o_rdy  (w_buf_rdy[0]),
        .o_val  (dst0_val),
        .o_data (w_dst0_flit),
        .i_rdy  (dst0_rdy)
    );

    demux_skid_buf #(.W(DATA_W + 1)) u_buf1 (
        .clk    (clk),
        .rst    (rst),
        .i_val  (w_push1),
        .i_data (w_src_flit),
        .o_rdy  (w_buf_rdy[1]),
        .o_val  (dst1_val),
        .o_data (w_dst1_flit),
        .i_rdy  (dst1_rdy)
    );

    assign {dst0_last, dst0_data} = w_dst0_flit;
    assign {dst1_last, dst1_data} = w_dst1_flit;

`ifdef PKT_DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Count messages as their last flit leaves each output; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (dst0_val && dst0_rdy && dst0_last) r_cnt0 <= r_cnt0 + 1'b1;
            if (dst1_val && dst1_rdy && dst1_last) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign dst0_msg_cnt = r_cnt0;
    assign dst1_msg_cnt = r_cnt1;
`endif

endmodule

// File: tb/tb_pkt_demux2.sv
// Bench for pkt_demux2: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pkt_demux2;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_val = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_last = 1'b0;
    logic          src_sel = 1'b0;
    logic          src_rdy;
    logic          dst0_val, dst1_val;
    logic [DW-1:0] dst0_data, dst1_data;
    logic          dst0_last, dst1_last;
    logic          dst0_rdy = 1'b1;
    logic          dst1_rdy = 1'b1;
`ifdef PKT_DEMUX_CNT_EN
    logic [CW-1:0] cnt0, cnt1;
    logic [CW-1:0] m_c0, m_c1;
`endif

    int tests = 0;
    int fails = 0;

    pkt_demux2 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_val   (src_val),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_sel   (src_sel),
        .src_rdy   (src_rdy),
        .dst0_val  (dst0_val),
        .dst0_data (dst0_data),
        .dst0_last (dst0_last),
        .dst0_rdy  (dst0_rdy),
        .dst1_val  (dst1_val),
        .dst1_data (dst1_data),
        .dst1_last (dst1_last),
        .dst1_rdy  (dst1_rdy)
`ifdef PKT_DEMUX_CNT_EN
       ,.dst0_msg_cnt (cnt0),
        .dst1_msg_cnt (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {last,data} per destination, capacity 2,
    // plus the message lock (in a message / locked destination).
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];
    bit          m_busy;
    bit          m_dest;
    bit          m_r;
    bit          m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            m_busy = 0;
            m_dest = 0;
`ifdef PKT_DEMUX_CNT_EN
            m_c0 = '0;
            m_c1 = '0;
`endif
        end else begin
            m_r   = m_busy ? m_dest : src_sel;
            m_acc = src_val && ((m_r ? q1.size() : q0.size()) < 2);
            if (q0.size() > 0 && dst0_rdy) begin
`ifdef PKT_DEMUX_CNT_EN
                if (q0[0][DW]) m_c0 = m_c0 + 1'b1;
`endif
                void'(q0.pop_front());
            end
            if (q1.size() > 0 && dst1_rdy) begin
`ifdef PKT_DEMUX_CNT_EN
                if (q1[0][DW]) m_c1 = m_c1 + 1'b1;
`endif
                void'(q1.pop_front());
            end
            if (m_acc) begin
                if (m_r) q1.push_back({src_last, src_data});
                else     q0.push_back({src_last, src_data});
                if (!m_busy && !src_last) begin
                    m_busy = 1;
                    m_dest = src_sel;
                end else if (m_busy && src_last) begin
                    m_busy = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_dst0_val", dst0_val, q0.size() != 0);
            chk("m_dst1_val", dst1_val, q1.size() != 0);
            if (q0.size() != 0) chk("m_dst0_flit", {dst0_last, dst0_data}, q0[0]);
            if (q1.size() != 0) chk("m_dst1_flit", {dst1_last, dst1_data}, q1[0]);
            chk("m_src_rdy", src_rdy,
                (((m_busy ? m_dest : src_sel) ? q1.size() : q0.size()) < 2));
`ifdef PKT_DEMUX_CNT_EN
            chk("m_cnt0", cnt0, m_c0);
            chk("m_cnt1", cnt1, m_c1);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic s);
        src_val  = v;
        src_data = d;
        src_last = l;
        src_sel  = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 8'h00, 0, 0);
        rst = 1;
        tick; tick;
        rst = 0;
        #1;
        chk("rst_dst0_val", dst0_val, 0);
        chk("rst_dst1_val", dst1_val, 0);
        chk("rst_dst0_data", dst0_data, 0);
        chk("rst_dst1_last", dst1_last, 0);
        chk("rst_src_rdy", src_rdy, 1);

        // 1: reset in the middle of a message destined for dst1
        dst1_rdy = 0;
        drive(1, 8'h20, 0, 1); tick;
        drive(1, 8'h21, 0, 1); tick;
        drive(0, 8'h00, 0, 1); tick; tick; tick;
        chk("t1_pre_dst1_val", dst1_val, 1);
        rst = 1;
        #1;
        chk("t1_async_dst1_val", dst1_val, 0);
        tick;
        rst = 0;
        dst1_rdy = 1;
        drive(0, 8'h00, 0, 0);
        #1;
        chk("t1_dst0_val", dst0_val, 0);
        chk("t1_dst1_val", dst1_val, 0);
        chk("t1_src_rdy", src_rdy, 1);
        drive(1, 8'h30, 1, 0); tick;
        chk("t1_new_dst0_val", dst0_val, 1);
        chk("t1_new_dst0_data", dst0_data, 8'h30);
        chk("t1_new_dst1_val", dst1_val, 0);
        drive(0, 8'h00, 0, 0); tick;

        // 2: four-flit message to dst1, src_sel toggled mid-message
        drive(1, 8'hA0, 0, 1); tick;
        chk("t2_a0", {dst1_val, dst1_last, dst1_data}, {2'b10, 8'hA0});
        chk("t2_d0_a0", dst0_val, 0);
        drive(1, 8'hA1, 0, 0); tick;
        chk("t2_a1", {dst1_val, dst1_last, dst1_data}, {2'b10, 8'hA1});
        chk("t2_d0_a1", dst0_val, 0);
        drive(1, 8'hA2, 0, 0); tick;
        chk("t2_a2", {dst1_val, dst1_last, dst1_data}, {2'b10, 8'hA2});
        chk("t2_d0_a2", dst0_val, 0);
        drive(1, 8'hA3, 1, 0); tick;
        chk("t2_a3", {dst1_val, dst1_last, dst1_data}, {2'b11, 8'hA3});
        chk("t2_d0_a3", dst0_val, 0);
        drive(0, 8'h00, 0, 0); tick;
        chk("t2_drained", dst1_val, 0);

        // 3: back-to-back single-flit messages
        drive(1, 8'h10, 1, 0);
        #1 chk("t3_rdy0", src_rdy, 1);
        tick;
        chk("t3_10", {dst0_val, dst0_data}, {1'b1, 8'h10});
        drive(1, 8'h11, 1, 1);
        #1 chk("t3_rdy1", src_rdy, 1);
        tick;
        chk("t3_11", {dst1_val, dst1_data}, {1'b1, 8'h11});
        drive(1, 8'h12, 1, 0);
        #1 chk("t3_rdy2", src_rdy, 1);
        tick;
        chk("t3_12", {dst0_val, dst0_data}, {1'b1, 8'h12});
        chk("t3_d1_empty", dst1_val, 0);
        drive(0, 8'h00, 0, 0); tick;

        // 4: dst0 stalled, three-flit message fills its buffer
        dst0_rdy = 0;
        drive(1, 8'hB0, 0, 0); tick;
        drive(1, 8'hB1, 0, 0); tick;
        drive(1, 8'hB2, 1, 0);
        #1 chk("t4_full_rdy", src_rdy, 0);
        tick;
        chk("t4_hold_rdy", src_rdy, 0);
        chk("t4_hold_data", dst0_data, 8'hB0);
        dst0_rdy = 1;
        tick;
        chk("t4_b1", {dst0_val, dst0_last, dst0_data}, {2'b10, 8'hB1});
        tick;
        chk("t4_b2", {dst0_val, dst0_last, dst0_data}, {2'b11, 8'hB2});
        drive(0, 8'h00, 0, 0); tick;
        chk("t4_drained", dst0_val, 0);

        // 5: dst0 full and stalled does not block a dst1 message
        dst0_rdy = 0;
        drive(1, 8'hD0, 0, 0); tick;
        drive(1, 8'hD1, 1, 0); tick;
        drive(1, 8'hC0, 1, 1);
        #1 chk("t5_rdy_sel1", src_rdy, 1);
        tick;
        chk("t5_c0", {dst1_val, dst1_data}, {1'b1, 8'hC0});
        chk("t5_d0_held", {dst0_val, dst0_data}, {1'b1, 8'hD0});
        drive(0, 8'h00, 0, 0);
        #1 chk("t5_rdy_sel0", src_rdy, 0);
        tick;
        chk("t5_d0_still", dst0_data, 8'hD0);
        dst0_rdy = 1;
        tick; tick; tick;
        chk("t5_drained", dst0_val, 0);

        // 6: nine messages to dst1 after a fresh reset
        rst = 1;
        tick;
        rst = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'h40 + 8'(i), 1, 1);
            tick;
        end
        chk("t6_last_flit", {dst1_val, dst1_data}, {1'b1, 8'h48});
        drive(0, 8'h00, 0, 0);
        tick; tick;
        chk("t6_d1_empty", dst1_val, 0);
`ifdef PKT_DEMUX_CNT_EN
        chk("t6_cnt1_wrap", cnt1, 1);
        chk("t6_cnt0", cnt0, 0);
`endif

        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
